// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the eight-input round-robin arbiter.
//   arb_state_t : FSM state encoding (ARB_IDLE, ARB_GRANT)
//   ARB_N       : number of requesters
//   ARB_PTR_RST : pointer reset value; requester 0 gets first priority
package arb_pkg;

    localparam int unsigned ARB_N       = 8;
    localparam logic [2:0]  ARB_PTR_RST = 3'd7;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick over eight request lines.
// The search starts at ptr+1 and wraps modulo 8. It rotates the requests,
// finds the first set bit and rotates the index back.
//   din      : request lines, bit i is requester i
//   ptr      : index of the last granted requester
//   pick     : one-hot winner, all-zero when din is zero
//   pick_idx : index of the winner (don't-care when din is zero)
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] din,
    input  logic [2:0]       ptr,
    output logic [ARB_N-1:0] pick,
    output logic [2:0]       pick_idx
);

    logic [2:0]         base;
    logic [2*ARB_N-1:0] dbl;
    logic [ARB_N-1:0]   rot;
    logic [2:0]         k;
    logic               found;

    always_comb begin
        base  = ptr + 3'd1;
        dbl   = {din, din};
        // rot[j] is the request of requester (base + j) mod 8
        rot   = dbl[base +: ARB_N];
        k     = '0;
        found = 1'b0;
        // Descending scan so the lowest set rotated position wins
        for (int unsigned i = ARB_N; i > 0; i--) begin
            if (rot[i-1]) begin
                k     = 3'(i - 1);
                found = 1'b1;
            end
        end
        pick_idx = base + k;
        pick     = found ? (8'd1 << pick_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-input round-robin arbiter with a registered, strictly
// one-hot grant. A grant is held until the owner asserts done or drops its
// request. One idle cycle always separates consecutive grants.
// Optional feature macro: RR_ARB_TIMEOUT_EN. When it is defined, a grant
// held for MAX_HOLD cycles is revoked and timeout pulses for one cycle.
//   MAX_HOLD  : maximum grant hold in cycles (2..256), timeout build only
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   din       : request lines
//   done      : owner releases its grant
//   dout      : registered one-hot grant, zero when idle
//   gnt_valid : registered, high whenever dout is non-zero
//   timeout   : one-cycle pulse on forced revocation (0 without the macro)
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ARB_N-1:0] din,
    input  logic             done,
    output logic [ARB_N-1:0] dout,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD out of range 2..256");
    end

    arb_state_t       state;
    logic [2:0]       ptr;
    logic [ARB_N-1:0] pick;
    logic [2:0]       pick_idx;
    logic             release_req;

    rr_pick8 u_pick (
        .din      (din),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // In GRANT the pointer always names the current owner
    assign release_req = done || !din[ptr];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned   CNT_W     = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_r;

    assign timeout = timeout_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            dout      <= '0;
            gnt_valid <= 1'b0;
            ptr       <= ARB_PTR_RST;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (|din) begin
                        state     <= ARB_GRANT;
                        dout      <= pick;
                        gnt_valid <= 1'b1;
                        ptr       <= pick_idx;
                        hold_cnt  <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (release_req) begin
                        state     <= ARB_IDLE;
                        dout      <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // ptr keeps the revoked owner so it ranks last next round
                        state     <= ARB_IDLE;
                        dout      <= '0;
                        gnt_valid <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    dout      <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            dout      <= '0;
            gnt_valid <= 1'b0;
            ptr       <= ARB_PTR_RST;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|din) begin
                        state     <= ARB_GRANT;
                        dout      <= pick;
                        gnt_valid <= 1'b1;
                        ptr       <= pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (release_req) begin
                        state     <= ARB_IDLE;
                        dout      <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    dout      <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed table-driven bench for rr_arbiter8, plus hand
// sequences for the hold / timeout behaviour and a random invariant run.
module tb_rr_arbiter8;

    localparam int unsigned TB_MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       done;
    logic [7:0] dout;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic       rst_n;
        logic [7:0] din;
        logic       done;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_to;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .done      (done),
        .dout      (dout),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] d, input logic dn,
                       input logic [7:0] ed, input logic et);
        vec_t v;
        v.rst_n     = r;
        v.din       = d;
        v.done      = dn;
        v.exp_dout  = ed;
        v.exp_valid = (ed != 8'h00);
        v.exp_to    = et;
        vecs.push_back(v);
    endtask

    // Apply inputs, cross one edge, sample 1 time unit later
    task automatic step(input logic r, input logic [7:0] d, input logic dn);
        rst_n = r;
        din   = d;
        done  = dn;
        @(posedge clk);
        #1;
    endtask

    // Invariant: grant is zero or one-hot, gnt_valid mirrors |dout
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(dout) || (gnt_valid !== (dout != 8'h00))) begin
                errors++;
                $display("FAIL invariant: dout %h gnt_valid %b", dout, gnt_valid);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        din   = '0;
        done  = 1'b0;

        // Test 1: 24 -> 04, release, then 20
        add(0, 8'h00, 0, 8'h00, 0);
        add(1, 8'h24, 0, 8'h04, 0);
        add(1, 8'h24, 1, 8'h00, 0);
        add(1, 8'h24, 0, 8'h20, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // Test 2: all requesting, done always high (ignored in IDLE)
        add(0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            add(1, 8'hFF, 1, 8'h01 << i, 0);
            add(1, 8'hFF, 1, 8'h00, 0);
        end
        add(1, 8'hFF, 1, 8'h01, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // Test 3: owner 3 drops request, ptr stays 3, 09 -> 01
        add(1, 8'h08, 0, 8'h08, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h09, 0, 8'h01, 0);
        add(1, 8'h09, 0, 8'h01, 0);
        add(1, 8'h09, 1, 8'h00, 0);
        add(1, 8'h09, 0, 8'h08, 0);
        add(1, 8'h09, 1, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // Test 4: reset mid-grant, then 11 -> 01
        add(1, 8'h10, 0, 8'h10, 0);
        add(0, 8'h10, 0, 8'h00, 0);
        add(1, 8'h11, 0, 8'h01, 0);
        add(1, 8'h11, 0, 8'h01, 0);
        add(1, 8'h10, 0, 8'h00, 0);
        add(1, 8'h11, 0, 8'h10, 0);
        add(1, 8'h00, 1, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].din, vecs[i].done);
            mon_en = 1'b1;
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_valid", i), {7'd0, gnt_valid}, {7'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_timeout", i), {7'd0, timeout}, {7'd0, vecs[i].exp_to});
        end

        step(0, 8'h00, 0);
`ifdef RR_ARB_TIMEOUT_EN
        // Forced revocation after TB_MAX_HOLD cycles, then regrant
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h02, 0);
            chk($sformatf("to_hold%0d", i), dout, 8'h02);
            chk($sformatf("to_hold%0d_pulse", i), {7'd0, timeout}, 8'h00);
        end
        step(1, 8'h02, 0);
        chk("to_revoke_dout", dout, 8'h00);
        chk("to_revoke_pulse", {7'd0, timeout}, 8'h01);
        step(1, 8'h02, 0);
        chk("to_regrant_dout", dout, 8'h02);
        chk("to_regrant_pulse", {7'd0, timeout}, 8'h00);
        // Release on the last allowed cycle wins over timeout
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h02, 0);
            chk($sformatf("to_rel_hold%0d", i), dout, 8'h02);
        end
        step(1, 8'h02, 1);
        chk("to_rel_dout", dout, 8'h00);
        chk("to_rel_pulse", {7'd0, timeout}, 8'h00);
`else
        // Without the timeout feature a grant is held indefinitely
        for (int i = 0; i < 40; i++) begin
            step(1, 8'h02, 0);
            chk($sformatf("hold%0d_dout", i), dout, 8'h02);
            chk($sformatf("hold%0d_timeout", i), {7'd0, timeout}, 8'h00);
        end
`endif

        // Random stimulus; the negedge monitor checks the invariant
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) != 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
